pc_config_parser: RTL and testbench

- First-stage parser for 32-bit words arriving from the host PC.
- Each word does one of three things:
  - passes through to the BD (chip) encoder as a leaf_code/payload pair;
  - writes one of Nreg 16-bit configuration registers;
  - is forwarded on one of Nchan 16-bit configuration channels.
- Sits between the PC input channel and the PC-mapper stage, which assigns register and channel meaning.

---
 rtl/pc_parser_pkg.sv | 31 +++
 rtl/pc_config_parser_if.sv | 11 +
 rtl/pc_word_decode.sv | 29 ++
 rtl/pc_config_parser.sv | 148 ++++++++++++++
 tb/tb_pc_config_parser.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_parser_pkg.sv
// Shared types and field positions for the PC configuration word parser.
package pc_parser_pkg;

    localparam int FPGA_OR_BD_BIT  = 31;
    localparam int REG_OR_CHAN_BIT = 30;
    localparam int ID_MSB          = 29;
    localparam int ID_LSB          = 24;
    localparam int ID_W            = 6;
    localparam int LEAF_W          = 6;
    localparam int BD_PAYLOAD_W    = 20;

    typedef enum logic [1:0] {
        BD_WORD      = 2'd0,
        REG_WORD     = 2'd1,
        CHANNEL_WORD = 2'd2
    } word_type_e;

    // Bit 31 separates chip-bound traffic from FPGA config; bit 30 picks register vs channel.
    function automatic word_type_e classify_word(input logic fpga_or_bd, input logic reg_or_chan);
        word_type_e t;
        if (!fpga_or_bd) begin
            t = BD_WORD;
        end else if (!reg_or_chan) begin
            t = REG_WORD;
        end else begin
            t = CHANNEL_WORD;
        end
        return t;
    endfunction

endpackage

// File: rtl/pc_config_parser_if.sv
// Valid/acknowledge word channel from the host PC into the parser.
interface pc_config_parser_if #(
    parameter int NPCin = 32
);
    logic [NPCin-1:0] pc_d;
    logic             pc_v;
    logic             pc_a;

    modport master (output pc_d, output pc_v, input  pc_a);
    modport slave  (input  pc_d, input  pc_v, output pc_a);
endinterface

// File: rtl/pc_word_decode.sv
// Pure combinational split of a 32-bit PC word into its fields, type and range flags.
module pc_word_decode
    import pc_parser_pkg::*;
#(
    parameter int NPCin = 32,
    parameter int Nconf = 16,
    parameter int Nreg  = 64,
    parameter int Nchan = 2
) (
    input  logic [NPCin-1:0]        i_word,
    output word_type_e              o_word_type,
    output logic [ID_W-1:0]         o_id,
    output logic [LEAF_W-1:0]       o_leaf_code,
    output logic [BD_PAYLOAD_W-1:0] o_payload,
    output logic [Nconf-1:0]        o_conf_data,
    output logic                    o_reg_in_range,
    output logic                    o_chan_in_range
);

    assign o_word_type     = classify_word(i_word[FPGA_OR_BD_BIT], i_word[REG_OR_CHAN_BIT]);
    assign o_id            = i_word[ID_MSB:ID_LSB];
    assign o_leaf_code     = i_word[ID_MSB:ID_LSB];
    assign o_payload       = i_word[BD_PAYLOAD_W-1:0];
    assign o_conf_data     = i_word[Nconf-1:0];
    // One extra bit so that Nreg/Nchan = 64 compares correctly against a 6-bit id.
    assign o_reg_in_range  = ({1'b0, o_id} < 7'(Nreg));
    assign o_chan_in_range = ({1'b0, o_id} < 7'(Nchan));

endmodule

// File: rtl/pc_config_parser.sv
// First-stage PC word parser: BD pass-through, config register file, config channel demux.
// Optional build macro PC_PARSER_DROP_CNT_EN adds a saturating count of out-of-range
// register/channel words on output drop_cnt.
module pc_config_parser
    import pc_parser_pkg::*;
#(
    parameter int NPCin = 32,
    parameter int Nconf = 16,
    parameter int Nreg  = 64,
    parameter int Nchan = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    pc_config_parser_if.slave       pc,
    input  logic [Nreg*Nconf-1:0]   conf_reg_reset_vals,
    output logic [Nreg*Nconf-1:0]   conf_reg_out,
    output logic [Nchan-1:0]        conf_chan_v,
    output logic [Nchan*Nconf-1:0]  conf_chan_d,
    input  logic [Nchan-1:0]        conf_chan_a,
    output logic                    bd_v,
    output logic [LEAF_W-1:0]       bd_leaf_code,
    output logic [BD_PAYLOAD_W-1:0] bd_payload,
    input  logic                    bd_a
`ifdef PC_PARSER_DROP_CNT_EN
    ,
    output logic [15:0]             drop_cnt
`endif
);

    word_type_e              w_word_type;
    logic [ID_W-1:0]         w_id;
    logic [LEAF_W-1:0]       w_leaf_code;
    logic [BD_PAYLOAD_W-1:0] w_payload;
    logic [Nconf-1:0]        w_conf_data;
    logic                    w_reg_in_range;
    logic                    w_chan_in_range;
    logic                    w_reg_we;
    logic [Nreg*Nconf-1:0]   r_conf_reg;

    pc_word_decode #(
        .NPCin (NPCin),
        .Nconf (Nconf),
        .Nreg  (Nreg),
        .Nchan (Nchan)
    ) u_decode (
        .i_word          (pc.pc_d),
        .o_word_type     (w_word_type),
        .o_id            (w_id),
        .o_leaf_code     (w_leaf_code),
        .o_payload       (w_payload),
        .o_conf_data     (w_conf_data),
        .o_reg_in_range  (w_reg_in_range),
        .o_chan_in_range (w_chan_in_range)
    );

`ifdef PC_PARSER_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;
`endif

    // Route the current word to exactly one destination and select the matching ack.
    always_comb begin
        conf_chan_v  = '0;
        conf_chan_d  = '0;
        bd_v         = 1'b0;
        bd_leaf_code = '0;
        bd_payload   = '0;
        pc.pc_a      = 1'b0;
        w_reg_we     = 1'b0;
`ifdef PC_PARSER_DROP_CNT_EN
        w_drop       = 1'b0;
`endif
        if (pc.pc_v) begin
            case (w_word_type)
                BD_WORD: begin
                    bd_v         = 1'b1;
                    bd_leaf_code = w_leaf_code;
                    bd_payload   = w_payload;
                    pc.pc_a      = bd_a;
                end
                REG_WORD: begin
                    // Registers never stall; out-of-range ids are acked and discarded.
                    pc.pc_a  = 1'b1;
                    w_reg_we = w_reg_in_range;
`ifdef PC_PARSER_DROP_CNT_EN
                    w_drop   = !w_reg_in_range;
`endif
                end
                CHANNEL_WORD: begin
                    if (w_chan_in_range) begin
                        for (int i = 0; i < Nchan; i++) begin
                            if (w_id == ID_W'(i)) begin
                                conf_chan_v[i]               = 1'b1;
                                conf_chan_d[i*Nconf +: Nconf] = w_conf_data;
                                pc.pc_a                      = conf_chan_a[i];
                            end else begin
                            end
                        end
                    end else begin
                        pc.pc_a = 1'b1;
`ifdef PC_PARSER_DROP_CNT_EN
                        w_drop  = 1'b1;
`endif
                    end
                end
                default: begin
                    pc.pc_a = 1'b0;
                end
            endcase
        end else begin
            pc.pc_a = 1'b0;
        end
    end

    // Config register file: reload reset values under reset, else write the addressed entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_conf_reg <= conf_reg_reset_vals;
        end else if (w_reg_we) begin
            for (int i = 0; i < Nreg; i++) begin
                if (w_id == ID_W'(i)) begin
                    r_conf_reg[i*Nconf +: Nconf] <= w_conf_data;
                end else begin
                end
            end
        end else begin
            r_conf_reg <= r_conf_reg;
        end
    end

    assign conf_reg_out = r_conf_reg;

`ifdef PC_PARSER_DROP_CNT_EN
    // Saturating count of accepted words whose register/channel id is out of range.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_pc_config_parser.sv
// Directed + random bench for pc_config_parser (Nreg = 4, Nchan = 4).
module tb_pc_config_parser;

    localparam int          NREG       = 4;
    localparam int          NCHAN      = 4;
    localparam logic [63:0] RESET_VALS = 64'h4444_3333_2222_1111;

    typedef struct packed {
        logic [1:0]  kind;   // 0 = BD, 2 = channel
        logic [5:0]  id;
        logic [19:0] val;
    } sb_entry_t;

    logic        clk;
    logic        reset;
    logic [63:0] conf_reg_reset_vals;
    logic [63:0] conf_reg_out;
    logic [3:0]  conf_chan_v;
    logic [63:0] conf_chan_d;
    logic [3:0]  conf_chan_a;
    logic        bd_v;
    logic [5:0]  bd_leaf_code;
    logic [19:0] bd_payload;
    logic        bd_a;
`ifdef PC_PARSER_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int          n_tests;
    int          n_fail;
    logic [63:0] shadow;
    int          exp_drop;
    sb_entry_t   sb_q[$];

    pc_config_parser_if #(.NPCin(32)) pc_bus ();

    pc_config_parser #(
        .NPCin (32),
        .Nconf (16),
        .Nreg  (NREG),
        .Nchan (NCHAN)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .pc                  (pc_bus),
        .conf_reg_reset_vals (conf_reg_reset_vals),
        .conf_reg_out        (conf_reg_out),
        .conf_chan_v         (conf_chan_v),
        .conf_chan_d         (conf_chan_d),
        .conf_chan_a         (conf_chan_a),
        .bd_v                (bd_v),
        .bd_leaf_code        (bd_leaf_code),
        .bd_payload          (bd_payload),
        .bd_a                (bd_a)
`ifdef PC_PARSER_DROP_CNT_EN
        ,
        .drop_cnt            (drop_cnt)
`endif
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the falling edge, then checks every combinational output and the registers.
    task automatic expect_comb(input string tag, input logic exp_a, input logic [3:0] exp_cv,
                               input logic [63:0] exp_cd, input logic exp_bv,
                               input logic [5:0] exp_leaf, input logic [19:0] exp_pl);
        @(negedge clk);
        check({tag, "_pc_a"},   {63'd0, pc_bus.pc_a}, {63'd0, exp_a});
        check({tag, "_chan_v"}, {60'd0, conf_chan_v}, {60'd0, exp_cv});
        check({tag, "_chan_d"}, conf_chan_d, exp_cd);
        check({tag, "_bd_v"},   {63'd0, bd_v}, {63'd0, exp_bv});
        check({tag, "_leaf"},   {58'd0, bd_leaf_code}, {58'd0, exp_leaf});
        check({tag, "_payload"}, {44'd0, bd_payload}, {44'd0, exp_pl});
        check({tag, "_regs"},   conf_reg_out, shadow);
    endtask

    task automatic check_drop(input string tag);
`ifdef PC_PARSER_DROP_CNT_EN
        check(tag, {48'd0, drop_cnt}, 64'(exp_drop));
`else
        exp_drop = exp_drop;
`endif
    endtask

    initial begin
        int        kind;
        int        id;
        logic [15:0] data;
        logic [5:0]  leaf;
        logic [19:0] pl;
        logic [31:0] word;
        logic        deliver;
        logic        done;
        logic        ea;
        logic [3:0]  ecv;
        logic [63:0] ecd;
        sb_entry_t   exp_e;
        sb_entry_t   obs_e;

        n_tests = 0;
        n_fail  = 0;
        exp_drop = 0;
        conf_reg_reset_vals = RESET_VALS;
        shadow      = RESET_VALS;
        reset       = 1'b0;
        pc_bus.pc_v = 1'b0;
        pc_bus.pc_d = 32'h0;
        bd_a        = 1'b0;
        conf_chan_a = 4'h0;

        // Reset held for two edges.
        tick();
        tick();
        expect_comb("reset", 1'b0, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        check_drop("reset_drop");
        reset = 1'b1;
        tick();

        // Register write: acked immediately, visible the next cycle.
        pc_bus.pc_d = 32'h8100ABCD;
        pc_bus.pc_v = 1'b1;
        expect_comb("regwr", 1'b1, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        tick();
        shadow[16 +: 16] = 16'hABCD;
        pc_bus.pc_v = 1'b0;
        expect_comb("regwr_after", 1'b0, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        tick();

        // Register write with ignored bits [23:16] set.
        pc_bus.pc_d = 32'h80FF5A5A;
        pc_bus.pc_v = 1'b1;
        expect_comb("regwr0", 1'b1, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        tick();
        shadow[0 +: 16] = 16'h5A5A;

        // Channel 2 held under backpressure, other channels' acks high.
        pc_bus.pc_d = 32'hC2001234;
        conf_chan_a = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            expect_comb("chan_bp", 1'b0, 4'b0100, 64'h0000_1234_0000_0000, 1'b0, 6'h0, 20'h0);
            tick();
        end
        conf_chan_a = 4'b0100;
        expect_comb("chan_ack", 1'b1, 4'b0100, 64'h0000_1234_0000_0000, 1'b0, 6'h0, 20'h0);
        tick();

        // BD pass-through, first stalled then acked.
        pc_bus.pc_d = 32'h0A0ABCDE;
        conf_chan_a = 4'hF;
        bd_a = 1'b0;
        expect_comb("bd_stall", 1'b0, 4'h0, 64'h0, 1'b1, 6'h0A, 20'hABCDE);
        tick();
        bd_a = 1'b1;
        expect_comb("bd_ack", 1'b1, 4'h0, 64'h0, 1'b1, 6'h0A, 20'hABCDE);
        tick();

        // BD word with bits 30 and [23:20] set; they must not leak into the fields.
        pc_bus.pc_d = 32'h75F12345;
        expect_comb("bd_ign", 1'b1, 4'h0, 64'h0, 1'b1, 6'h35, 20'h12345);
        tick();

        // Out-of-range register and channel ids are acked and dropped.
        pc_bus.pc_d = 32'h85000001;
        expect_comb("reg_oor", 1'b1, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        tick();
        exp_drop++;
        pc_bus.pc_d = 32'hC7000001;
        conf_chan_a = 4'h0;
        expect_comb("chan_oor", 1'b1, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        tick();
        exp_drop++;
        pc_bus.pc_v = 1'b0;
        expect_comb("oor_after", 1'b0, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        check_drop("drop_two");
        tick();

        // Highest id on a register word.
        pc_bus.pc_d = 32'hBF00FFFF;
        pc_bus.pc_v = 1'b1;
        expect_comb("reg_id63", 1'b1, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        tick();
        exp_drop++;

        // No valid: nothing downstream, no ack, even with every ack high.
        pc_bus.pc_v = 1'b0;
        pc_bus.pc_d = 32'hC0001111;
        conf_chan_a = 4'hF;
        bd_a = 1'b1;
        expect_comb("idle", 1'b0, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        check_drop("drop_three");
        tick();

        // Reset mid-operation overrides a concurrent register write.
        pc_bus.pc_d = 32'h8300BEEF;
        pc_bus.pc_v = 1'b1;
        reset = 1'b0;
        tick();
        shadow   = RESET_VALS;
        exp_drop = 0;
        pc_bus.pc_v = 1'b0;
        reset = 1'b1;
        expect_comb("mid_reset", 1'b0, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        check_drop("mid_reset_drop");
        tick();

        // Random mix with random downstream acks.
        for (int w = 0; w < 1000; w++) begin
            kind = $urandom_range(0, 2);
            id   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 3);
            data = 16'($urandom);
            leaf = 6'($urandom);
            pl   = 20'($urandom);
            deliver = 1'b0;
            if (kind == 0) begin
                word = {1'b0, 1'($urandom), leaf, 4'($urandom), pl};
                deliver = 1'b1;
                sb_q.push_back('{kind: 2'd0, id: leaf, val: pl});
            end else if (kind == 1) begin
                word = {2'b10, 6'(id), 8'($urandom), data};
            end else begin
                word = {2'b11, 6'(id), 8'($urandom), data};
                if (id < NCHAN) begin
                    deliver = 1'b1;
                    sb_q.push_back('{kind: 2'd2, id: 6'(id), val: {4'h0, data}});
                end else begin
                end
            end
            done = 1'b0;
            for (int c = 0; c < 64 && !done; c++) begin
                pc_bus.pc_d = word;
                pc_bus.pc_v = 1'b1;
                bd_a        = 1'($urandom_range(0, 1));
                conf_chan_a = 4'($urandom_range(0, 15));
                ecv = 4'h0;
                ecd = 64'h0;
                if (kind == 0) begin
                    ea = bd_a;
                    expect_comb("rnd_bd", ea, ecv, ecd, 1'b1, leaf, pl);
                end else if (kind == 1) begin
                    ea = 1'b1;
                    expect_comb("rnd_reg", ea, ecv, ecd, 1'b0, 6'h0, 20'h0);
                end else if (id < NCHAN) begin
                    ea = conf_chan_a[id];
                    ecv[id] = 1'b1;
                    ecd[id*16 +: 16] = data;
                    expect_comb("rnd_chan", ea, ecv, ecd, 1'b0, 6'h0, 20'h0);
                end else begin
                    ea = 1'b1;
                    expect_comb("rnd_chan_oor", ea, ecv, ecd, 1'b0, 6'h0, 20'h0);
                end
                if (ea && deliver) begin
                    obs_e = '1;
                    if (bd_v) begin
                        obs_e = '{kind: 2'd0, id: bd_leaf_code, val: bd_payload};
                    end else begin
                        for (int i = 0; i < NCHAN; i++) begin
                            if (conf_chan_v[i]) begin
                                obs_e = '{kind: 2'd2, id: 6'(i), val: {4'h0, conf_chan_d[i*16 +: 16]}};
                            end else begin
                            end
                        end
                    end
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 64'd1, 64'd0);
                    end else begin
                        exp_e = sb_q.pop_front();
                        check("sb_deliver", {36'd0, obs_e}, {36'd0, exp_e});
                    end
                end else begin
                end
                tick();
                if (ea) begin
                    done = 1'b1;
                    if (kind == 1 && id < NREG) begin
                        shadow[id*16 +: 16] = data;
                    end else if (kind != 0 && ((kind == 1) ? (id >= NREG) : (id >= NCHAN))) begin
                        exp_drop = (exp_drop < 65535) ? exp_drop + 1 : exp_drop;
                    end else begin
                    end
                end else begin
                end
            end
            if (!done) begin
                check("rnd_timeout", 64'd0, 64'd1);
            end else begin
            end
            if ($urandom_range(0, 3) == 0) begin
                pc_bus.pc_v = 1'b0;
                expect_comb("rnd_idle", 1'b0, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
                tick();
            end else begin
            end
        end

        pc_bus.pc_v = 1'b0;
        expect_comb("final", 1'b0, 4'h0, 64'h0, 1'b0, 6'h0, 20'h0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check_drop("final_drop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
